// File: rtl/tpu_activation_skewer.sv
// tpu_activation_skewer
//
// Upstream feeder for the TPU systolic array. The block accepts one
// activation vector per beat, with one element per array row, over a
// valid/ready handshake. It emits the vector diagonally skewed: row lane i
// leaves i steps later than lane 0. This gives the wavefront that the
// array's left-edge inputs expect.
//
// After the last vector of a tile, the block shifts zeros in until the
// final element has left the deepest lane. It then pulses tile_done.
//
// Optional feature: define TPU_SKEW_PERF_EN to build the beat and stall
// performance counters. Without it, beat_count and stall_count are tied
// to zero.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     upstream vector valid
//   in_ready     vector accepted this cycle (combinational)
//   in_data      vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last      marks the final vector of a tile
//   out_ready    array can advance one step this cycle
//   abort        synchronous clear of lanes and control state
//   a_out        skewed lanes, same packing as in_data
//   lane_valid   per-lane real-data tag (0 = fill)
//   out_valid    OR of lane_valid
//   busy         control state is not IDLE
//   tile_done    one-cycle pulse when the flush completes
//   beat_count   accepted vectors (perf build only)
//   stall_count  cycles with in_valid high and in_ready low (perf build only)
module tpu_activation_skewer #(
  parameter int ARRAY_SIZE = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] in_data,
  input  logic                             in_last,
  input  logic                             out_ready,
  input  logic                             abort,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] a_out,
  output logic [ARRAY_SIZE-1:0]            lane_valid,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             tile_done,
  output logic [31:0]                      beat_count,
  output logic [31:0]                      stall_count
);

  localparam int CNT_W = $clog2(ARRAY_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_next;
  logic             tile_done_next;
  logic             step;  // every lane shifts by one position
  logic             fill;  // the shifted-in element is zero fill

  assign in_ready = out_ready && (state != FLUSH) && !abort;

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    tile_done_next = 1'b0;
    step           = 1'b0;
    fill           = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (in_valid && in_ready) begin
          step = 1'b1;
          if (in_last) begin
            state_next     = FLUSH;
            flush_cnt_next = CNT_W'(ARRAY_SIZE - 1);
          end else begin
            state_next = STREAM;
          end
        end
      end
      FLUSH: begin
        if (out_ready) begin
          step           = 1'b1;
          fill           = 1'b1;
          flush_cnt_next = flush_cnt - CNT_W'(1);
          // This step pushes the tile's final element out of the deepest lane.
          if (flush_cnt == CNT_W'(1)) begin
            state_next     = IDLE;
            tile_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // abort outranks everything, including a flush step in progress
    if (abort) begin
      state_next     = IDLE;
      flush_cnt_next = '0;
      tile_done_next = 1'b0;
      step           = 1'b0;
      fill           = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      tile_done <= tile_done_next;
    end
  end

  assign busy = (state != IDLE);

  // Lane gi is a shift line of gi+1 stages, each holding data and a valid tag.
  // A common step keeps the diagonal skew intact with no bubbles.
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] data_reg [gi+1];
    logic [gi:0]           tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= gi; j++) begin
          data_reg[j] <= '0;
        end
        tag_reg <= '0;
      end else if (abort) begin
        for (int j = 0; j <= gi; j++) begin
          data_reg[j] <= '0;
        end
        tag_reg <= '0;
      end else if (step) begin
        data_reg[0] <= fill ? '0 : in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        tag_reg[0]  <= !fill;
        for (int j = 1; j <= gi; j++) begin
          data_reg[j] <= data_reg[j-1];
          tag_reg[j]  <= tag_reg[j-1];
        end
      end
    end

    assign a_out[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg[gi];
    assign lane_valid[gi]                     = tag_reg[gi];
  end

  // Derived only from lane flops, so this output stays free of input paths.
  assign out_valid = |lane_valid;

`ifdef TPU_SKEW_PERF_EN
  logic [31:0] beat_reg;
  logic [31:0] stall_reg;

  // Counters survive abort; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg  <= '0;
      stall_reg <= '0;
    end else begin
      if (in_valid && in_ready) begin
        beat_reg <= beat_reg + 32'd1;
      end
      if (in_valid && !in_ready) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end
  end

  assign beat_count  = beat_reg;
  assign stall_count = stall_reg;
`else
  assign beat_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_tpu_activation_skewer.sv
module tb_tpu_activation_skewer;

  localparam int AS = 4;
  localparam int DW = 8;
  localparam int VW = AS * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic          out_ready;
  logic          abort;
  logic [VW-1:0] a_out;
  logic [AS-1:0] lane_valid;
  logic          out_valid;
  logic          busy;
  logic          tile_done;
  logic [31:0]   beat_count;
  logic [31:0]   stall_count;

  always #5 clk = ~clk;

  tpu_activation_skewer #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_ready(out_ready), .abort(abort),
    .a_out(a_out), .lane_valid(lane_valid), .out_valid(out_valid), .busy(busy),
    .tile_done(tile_done), .beat_count(beat_count), .stall_count(stall_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a history of what entered stage 0 at each step.
  // After step s, lane i shows the entry from step s-i.
  typedef struct {
    logic [VW-1:0] d;
    bit            v;
  } ent_t;

  ent_t        hist[$];
  int          flush_rem;   // fill steps still owed by the current tile
  bit          in_tile;     // beats accepted, last not yet seen
  bit          done_exp;
  logic [31:0] beats_exp;
  logic [31:0] stalls_exp;
  bit          acc_o;       // last cycle accepted a beat
  bit          step_o;      // last cycle took any step

  task automatic model_clear();
    hist.delete();
    flush_rem  = 0;
    in_tile    = 0;
    done_exp   = 0;
    beats_exp  = 0;
    stalls_exp = 0;
  endtask

  task automatic check_outputs(input string sfx);
    logic [VW-1:0] ea;
    logic [AS-1:0] ev;
    int            idx;
    ent_t          e;
    ea = '0;
    ev = '0;
    for (int i = 0; i < AS; i++) begin
      idx = hist.size() - 1 - i;
      if (idx >= 0) begin
        e = hist[idx];
        ea[i*DW +: DW] = e.d[i*DW +: DW];
        ev[i]          = e.v;
      end
    end
    check_value({"a_out", sfx}, a_out, ea);
    check_value({"lane_valid", sfx}, lane_valid, ev);
    check_value({"out_valid", sfx}, out_valid, |ev);
    check_value({"busy", sfx}, busy, in_tile || flush_rem > 0);
    check_value({"tile_done", sfx}, tile_done, done_exp);
`ifdef TPU_SKEW_PERF_EN
    check_value({"beat_count", sfx}, beat_count, beats_exp);
    check_value({"stall_count", sfx}, stall_count, stalls_exp);
`else
    check_value({"beat_count", sfx}, beat_count, 0);
    check_value({"stall_count", sfx}, stall_count, 0);
`endif
  endtask

  // One clock cycle: entered and left at a negedge.
  task automatic cycle(input bit v, input logic [VW-1:0] d, input bit last,
                       input bit ordy, input bit ab);
    bit   rdy_exp;
    bit   fl;
    ent_t e;
    in_valid  = v;
    in_data   = d;
    in_last   = last;
    out_ready = ordy;
    abort     = ab;
    #1;
    rdy_exp = ordy && flush_rem == 0 && !ab;
    check_value("in_ready", in_ready, rdy_exp);
    acc_o  = v && rdy_exp;
    fl     = !ab && flush_rem > 0 && ordy;
    step_o = acc_o || fl;
    @(posedge clk);
    #1;
    if (v && !rdy_exp) stalls_exp++;
    if (acc_o) beats_exp++;
    if (ab) begin
      hist.delete();
      flush_rem = 0;
      in_tile   = 0;
      done_exp  = 0;
    end else begin
      done_exp = fl && flush_rem == 1;
      if (acc_o) begin
        e.d = d;
        e.v = 1'b1;
        hist.push_back(e);
        if (last) begin
          flush_rem = AS - 1;
          in_tile   = 0;
        end else begin
          in_tile = 1;
        end
      end
      if (fl) begin
        e.d = '0;
        e.v = 1'b0;
        hist.push_back(e);
        flush_rem--;
      end
    end
    check_outputs("");
    $display("cycle v=%0d last=%0d ordy=%0d abort=%0d d=%h -> a_out=%h lv=%b done=%0d",
             v, last, ordy, ab, d, a_out, lane_valid, tile_done);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs("@reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [VW-1:0] beat3(input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return {8'h40 | kk, 8'h30 | kk, 8'h20 | kk, 8'h10 | kk};
  endfunction

  logic [VW-1:0] seq_a[$];
  logic [AS-1:0] seq_v[$];

  initial begin
    int n;
    int b;
    int done_step;
    bit ordy;
    rst_n     = 1'b0;
    in_valid  = 0;
    in_data   = '0;
    in_last   = 0;
    out_ready = 0;
    abort     = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_outputs("@reset");
    rst_n = 1'b1;

    // Single 1-beat tile: each lane shows its byte in turn.
    cycle(1, 32'h04030201, 1, 1, 0);
    for (int i = 0; i < AS; i++) begin
      if (i > 0) cycle(0, '0, 0, 1, 0);
      check_value("single_lane_data", a_out[i*DW +: DW], 8'(i + 1));
      check_value("single_lane_valid", lane_valid, 4'b0001 << i);
    end
    check_value("single_tile_done", tile_done, 1);
    cycle(0, '0, 0, 1, 0);

    // 3-beat tile with out_ready high; record the step-by-step output.
    seq_a.delete();
    seq_v.delete();
    done_step = -1;
    for (int s = 0; s < 12 && done_step < 0; s++) begin
      if (s < 3) cycle(1, beat3(s), s == 2, 1, 0);
      else cycle(0, '0, 0, 1, 0);
      seq_a.push_back(a_out);
      seq_v.push_back(lane_valid);
      if (tile_done) done_step = s + 1;
    end
    check_value("tile3_done_steps", done_step, 6);

    // Same tile with out_ready toggling: same sequence, stretched.
    b = 0;
    n = 0;
    ordy = 1;
    for (int c = 0; c < 30 && n < seq_a.size(); c++) begin
      cycle(b < 3, beat3(b), b == 2, ordy, 0);
      if (step_o) begin
        check_value("toggle_a_out", a_out, seq_a[n]);
        check_value("toggle_lane_valid", lane_valid, seq_v[n]);
        n++;
      end
      if (acc_o) b++;
      ordy = !ordy;
    end
    check_value("toggle_step_count", n, seq_a.size());
    cycle(0, '0, 0, 1, 0);

    // abort in FLUSH with two fill steps left.
    cycle(1, 32'haabbccdd, 0, 1, 0);
    cycle(1, 32'h11223344, 1, 1, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 1, 1);
    check_value("abort_a_out", a_out, 0);
    check_value("abort_lane_valid", lane_valid, 0);
    check_value("abort_busy", busy, 0);
    for (int c = 0; c < 4; c++) begin
      cycle(0, '0, 0, 1, 0);
      check_value("abort_no_done", tile_done, 0);
    end
    for (int s = 0; s < 6; s++) cycle(s < 2, beat3(s + 5), s == 1, 1, 0);

    // Back-to-back: present a new first beat in the tile_done cycle.
    cycle(1, 32'h0a0b0c0d, 1, 1, 0);
    for (int c = 0; c < 10 && !tile_done; c++) cycle(0, '0, 0, 1, 0);
    check_value("b2b_done_seen", tile_done, 1);
    cycle(1, 32'h5a6b7c8d, 0, 1, 0);
    check_value("b2b_accepted", acc_o, 1);
    check_value("b2b_lane0", a_out[DW-1:0], 8'h8d);
    check_value("b2b_lane_valid", lane_valid, 4'b0001);
    cycle(0, '0, 1, 1, 0);
    for (int c = 0; c < 6; c++) cycle(0, '0, 0, 1, 0);

    // Counters: 5 beats, then 7 FLUSH cycles with in_valid held high.
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1, $urandom, k == 4, 1, 0);
    cycle(1, '0, 0, 0, 0);
    cycle(1, '0, 0, 0, 0);
    cycle(1, '0, 0, 1, 0);
    cycle(1, '0, 0, 0, 0);
    cycle(1, '0, 0, 1, 0);
    cycle(1, '0, 0, 0, 0);
    cycle(1, '0, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
`ifdef TPU_SKEW_PERF_EN
    check_value("perf_beats", beat_count, 5);
    check_value("perf_stalls", stall_count, 7);
`else
    check_value("perf_beats_off", beat_count, 0);
    check_value("perf_stalls_off", stall_count, 0);
`endif

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
